// File: rtl/mmio_uart_responder_if.sv
// CPU data-port and UART byte-stream signals seen by mmio_uart_responder.
// master = CPU/UART side, slave = responder.
`timescale 1ns/1ps
interface mmio_uart_responder_if;
  logic [31:0] mmio_addr;
  logic        mmio_re;
  logic        mmio_we;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        inst_retire;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Streams: a byte moves on a rising clk edge where valid && ready are both high.
  modport master (
    output mmio_addr, mmio_re, mmio_we, mmio_wdata, inst_retire,
    output rx_data, rx_valid, tx_ready,
    input  mmio_rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  mmio_addr, mmio_re, mmio_we, mmio_wdata, inst_retire,
    input  rx_data, rx_valid, tx_ready,
    output mmio_rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_uart_responder.sv
// MMIO responder for the 0x8000_0000 window: UART RX/TX FIFOs, status, perf counters.
// Define MMIO_COUNTERS_EN to build the cycle/instruction counters.
`timescale 1ns/1ps
module mmio_uart_responder #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    mmio_uart_responder_if.slave  bus
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;

    logic       sel, wr_en, rd_en;
    logic [7:0] off;

    // A simultaneous load and store is treated as a store only.
    assign sel   = (bus.mmio_addr[31:28] == 4'h8);
    assign off   = bus.mmio_addr[7:0];
    assign wr_en = sel & bus.mmio_we;
    assign rd_en = sel & bus.mmio_re & ~bus.mmio_we;

    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wptr, rx_rptr;
    logic [RXW:0] rx_count, rx_count_nxt;
    logic         rx_full, rx_empty, rx_ovf, rx_push, rx_pop;

    assign rx_push      = bus.rx_valid & ~rx_full;
    assign rx_pop       = rd_en & (off == OFF_RXDATA) & ~rx_empty;
    assign rx_count_nxt = rx_count + {{RXW{1'b0}}, rx_push} - {{RXW{1'b0}}, rx_pop};
    assign bus.rx_ready = ~rx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            rx_full  <= 1'b0;
            rx_empty <= 1'b1;
            rx_ovf   <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            rx_count <= rx_count_nxt;
            rx_full  <= (rx_count_nxt == (RXW+1)'(RX_DEPTH));
            rx_empty <= (rx_count_nxt == '0);
            // A new overflow in the same cycle as a status read stays visible.
            if (bus.rx_valid && rx_full)                rx_ovf <= 1'b1;
            else if (rd_en && (off == OFF_STATUS))      rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= bus.rx_data;
    end

    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wptr, tx_rptr;
    logic [TXW:0] tx_count, tx_count_nxt;
    logic         tx_full, tx_empty, tx_push, tx_pop;

    assign tx_push      = wr_en & (off == OFF_TXDATA) & ~tx_full;
    assign tx_pop       = ~tx_empty & bus.tx_ready;
    assign tx_count_nxt = tx_count + {{TXW{1'b0}}, tx_push} - {{TXW{1'b0}}, tx_pop};
    assign bus.tx_valid = ~tx_empty;
    assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            tx_count <= tx_count_nxt;
            tx_full  <= (tx_count_nxt == (TXW+1)'(TX_DEPTH));
            tx_empty <= (tx_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.mmio_wdata[7:0];
    end

    logic [31:0] cycle_rd, instr_rd;
`ifdef MMIO_COUNTERS_EN
    localparam logic [7:0] OFF_CLEAR = 8'h18;
    logic [31:0] cycle_cnt, instr_cnt;
    logic        cnt_clr;

    assign cnt_clr = wr_en & (off == OFF_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (cnt_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            instr_cnt <= instr_cnt + {31'd0, bus.inst_retire};
        end
    end

    assign cycle_rd = cycle_cnt;
    assign instr_rd = instr_cnt;
    logic unused_bits;
    assign unused_bits = ^{bus.mmio_addr[27:8], bus.mmio_wdata[31:8]};
`else
    assign cycle_rd = 32'd0;
    assign instr_rd = 32'd0;
    logic unused_bits;
    assign unused_bits = ^{bus.mmio_addr[27:8], bus.mmio_wdata[31:8], bus.inst_retire};
`endif

    logic [31:0] rd_val, rdata_q;

    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_STATUS: rd_val = {29'd0, rx_ovf, ~rx_empty, ~tx_full};
            OFF_RXDATA: rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr]};
            OFF_CYCLE:  rd_val = cycle_rd;
            OFF_INSTR:  rd_val = instr_rd;
            default:    rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= 32'd0;
        else if (rd_en) rdata_q <= rd_val;
    end

    assign bus.mmio_rdata = rdata_q;
endmodule

// File: tb/tb_mmio_uart_responder.sv
// Self-checking bench for mmio_uart_responder: vector table plus hand-written
// RX overflow, TX backpressure, counter and reset sequences.
`timescale 1ns/1ps
module tb_mmio_uart_responder;
  localparam int RX_DEPTH = 8;
  localparam int TX_DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mmio_uart_responder_if bus();

  mmio_uart_responder #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        tx_push;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mmio_addr  = 32'd0;
    bus.mmio_re    = 1'b0;
    bus.mmio_we    = 1'b0;
    bus.mmio_wdata = 32'd0;
  endtask

  task automatic mmio_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.mmio_addr = a;
    bus.mmio_re   = 1'b1;
    exp_q.push_back(exp);
    if (a[31:28] == 4'h8 && a[7:0] == 8'h04 && exp_rx_q.size() > 0)
      void'(exp_rx_q.pop_front());
    tick();
    idle_bus();
    check(name, bus.mmio_rdata, exp_q.pop_front());
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    bus.mmio_addr  = a;
    bus.mmio_we    = 1'b1;
    bus.mmio_wdata = d;
    if (a[31:28] == 4'h8 && a[7:0] == 8'h08 && exp_tx_q.size() < TX_DEPTH)
      exp_tx_q.push_back(d[7:0]);
    tick();
    idle_bus();
  endtask

  task automatic rx_send(input logic [7:0] b, input string name);
    check(name, {31'd0, bus.rx_ready}, {31'd0, exp_rx_q.size() < RX_DEPTH});
    if (exp_rx_q.size() < RX_DEPTH) exp_rx_q.push_back(b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic rx_drain(input string name);
    int n;
    n = exp_rx_q.size();
    for (int i = 0; i < n; i++)
      mmio_read(32'h8000_0004, {24'd0, exp_rx_q[0]}, name);
  endtask

  task automatic tx_drain(input string name);
    int budget;
    budget = 0;
    bus.tx_ready = 1'b1;
    while (exp_tx_q.size() > 0 && budget < 50) begin
      if (bus.tx_valid) check(name, {24'd0, bus.tx_data}, {24'd0, exp_tx_q.pop_front()});
      tick();
      budget++;
    end
    if (exp_tx_q.size() != 0) begin
      check({name, "_timeout"}, exp_tx_q.size(), 0);
      exp_tx_q.delete();
    end
    check({name, "_empty"}, {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int retire_cnt;

    tbl[0]  = '{32'h8000_0000, 1'b1, 1'b0, 32'h0,  32'h3,  1'b0};
    tbl[1]  = '{32'h8000_0004, 1'b1, 1'b0, 32'h0,  32'h41, 1'b0};
    tbl[2]  = '{32'h8ABC_DE04, 1'b1, 1'b0, 32'h0,  32'h42, 1'b0};
    tbl[3]  = '{32'h8000_0004, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[4]  = '{32'h8000_0000, 1'b1, 1'b0, 32'h0,  32'h1,  1'b0};
    tbl[5]  = '{32'h8000_000C, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[6]  = '{32'h8000_0000, 1'b1, 1'b0, 32'h0,  32'h1,  1'b0};
    tbl[7]  = '{32'h4000_0000, 1'b1, 1'b0, 32'h0,  32'h1,  1'b0};
    tbl[8]  = '{32'h8000_0008, 1'b1, 1'b1, 32'h5A, 32'h1,  1'b1};
    tbl[9]  = '{32'h8000_0000, 1'b1, 1'b0, 32'h0,  32'h1,  1'b0};
    tbl[10] = '{32'h4000_0008, 1'b0, 1'b1, 32'h77, 32'h1,  1'b0};
    tbl[11] = '{32'h8000_0020, 1'b0, 1'b1, 32'h99, 32'h1,  1'b0};

    idle_bus();
    bus.inst_retire = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.tx_ready    = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_rdata",    bus.mmio_rdata, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data",  {24'd0, bus.tx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    mmio_read(32'h8000_0000, 32'h1, "status_after_reset");

    // RX two bytes then the vector table
    rx_send(8'h41, "rx_ready_a");
    rx_send(8'h42, "rx_ready_b");
    for (int i = 0; i < 12; i++) begin
      bus.mmio_addr  = tbl[i].addr;
      bus.mmio_re    = tbl[i].re;
      bus.mmio_we    = tbl[i].we;
      bus.mmio_wdata = tbl[i].wdata;
      exp_q.push_back(tbl[i].exp);
      if (tbl[i].tx_push) exp_tx_q.push_back(tbl[i].wdata[7:0]);
      if (tbl[i].re && !tbl[i].we && tbl[i].addr[31:28] == 4'h8 &&
          tbl[i].addr[7:0] == 8'h04 && exp_rx_q.size() > 0)
        void'(exp_rx_q.pop_front());
      tick();
      idle_bus();
      check($sformatf("vec%0d", i), bus.mmio_rdata, exp_q.pop_front());
    end
    tx_drain("tx_table");

    // RX overflow: RX_DEPTH+1 random bytes with no reads
    for (int i = 0; i < RX_DEPTH + 1; i++)
      rx_send(8'($urandom_range(0, 255)), $sformatf("ovf_rx_ready%0d", i));
    check("ovf_rx_ready_low", {31'd0, bus.rx_ready}, 32'd0);
    mmio_read(32'h8000_0000, 32'h7, "status_ovf");
    mmio_read(32'h8000_0000, 32'h3, "status_ovf_cleared");
    rx_drain("rx_byte");
    mmio_read(32'h8000_0000, 32'h1, "status_rx_drained");

    // TX backpressure: ten writes, only the first TX_DEPTH survive
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mmio_write(32'h8000_0008, i);
      if (i == TX_DEPTH - 1) begin
        check("tx_valid_full", {31'd0, bus.tx_valid}, 32'd1);
        mmio_read(32'h8000_0000, 32'h0, "status_tx_full");
      end
    end
    tx_drain("tx_byte");
    mmio_read(32'h8000_0000, 32'h1, "status_tx_drained");

`ifdef MMIO_COUNTERS_EN
    mmio_write(32'h8000_0018, 32'hDEAD_BEEF);
    for (int c = 0; c < 20; c++) begin
      bus.inst_retire = (c % 4 == 0);
      tick();
    end
    bus.inst_retire = 1'b0;
    mmio_read(32'h8000_0014, 32'd5, "instr_5");

    mmio_write(32'h8000_0018, 32'h0);
    retire_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      bus.inst_retire = 1'($urandom_range(0, 1));
      if (bus.inst_retire) retire_cnt++;
      tick();
    end
    bus.inst_retire = 1'b0;
    mmio_read(32'h8000_0014, retire_cnt, "instr_random");

    // clear wins over a same-cycle retire
    bus.inst_retire = 1'b1;
    mmio_write(32'h8000_0018, 32'h0);
    bus.inst_retire = 1'b0;
    mmio_read(32'h8000_0014, 32'd0, "instr_clear_prio");

    mmio_write(32'h8000_0018, 32'h0);
    mmio_read(32'h8000_0010, 32'd0, "cycle_after_clear0");
    mmio_read(32'h8000_0010, 32'd1, "cycle_after_clear1");
    mmio_read(32'h8000_0010, 32'd2, "cycle_after_clear2");
`else
    retire_cnt = 0;
    bus.inst_retire = 1'b1;
    mmio_write(32'h8000_0018, 32'h0);
    bus.inst_retire = 1'b0;
    mmio_read(32'h8000_0000, 32'h1, "status_pre_cnt");
    mmio_read(32'h8000_0010, 32'd0, "cycle_absent");
    mmio_read(32'h8000_0000, 32'h1, "status_mid_cnt");
    mmio_read(32'h8000_0014, 32'd0, "instr_absent");
`endif

    // reset in the middle of a TX drain
    mmio_write(32'h8000_0008, 32'hA0);
    mmio_write(32'h8000_0008, 32'hA1);
    mmio_write(32'h8000_0008, 32'hA2);
    mmio_read(32'h8000_0000, 32'h1, "status_before_rst");
    bus.tx_ready = 1'b1;
    check("midrst_byte0", {24'd0, bus.tx_data}, {24'd0, exp_tx_q.pop_front()});
    tick();
    check("midrst_byte1", {24'd0, bus.tx_data}, {24'd0, exp_tx_q[0]});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midrst_tx_data",  {24'd0, bus.tx_data}, 32'd0);
    check("midrst_rdata",    bus.mmio_rdata, 32'd0);
    check("midrst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    exp_tx_q.delete();
    exp_rx_q.delete();
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    mmio_read(32'h8000_0000, 32'h1, "status_after_midrst");
    check("tx_valid_after_midrst", {31'd0, bus.tx_valid}, 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
